// File: rtl/ru_mem_arbiter.sv
// ru_mem_arbiter
//   Shares one single-port, registered-read word RAM between an instruction
//   fetch port (I) and a load/store port (D). It grants one requester at a
//   time and waits out the RAM's 1-cycle read latency. Byte-enable stores are
//   emulated by reading the old word and writing back the merged result.
//
//   Optional feature macro: RU_ARB_RR_EN
//     undefined : fixed priority, D wins on contention
//     defined   : round-robin on contention; last grant resets to I
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_req/i_addr        fetch request (held until i_ack), byte address
//   i_rdata/i_ack       registered fetch data, one-cycle completion pulse
//   d_req/d_we/d_be     data request, store flag, store byte enables
//   d_addr/d_wdata      data byte address, lane-aligned store data
//   d_rdata/d_ack       registered load data, one-cycle completion pulse
//   mem_addr/mem_din    RAM word address and write data
//   mem_we/mem_dout     RAM write enable and registered read data
module ru_mem_arbiter #(
    parameter  int ADDR_W = 12,
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [BE_W-1:0]   d_be,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {IDLE, READ, ACK} state_t;

    state_t              state_q, state_d;
    logic                sel_d_q, sel_d_d;   // granted port is D
    logic                st_q, st_d;         // granted op is a store
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                last_d_q, last_d_d; // last grant went to D
    logic                gnt_d;

    // Byte-offset and high address bits are intentionally ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0], last_d_q};

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    always_comb begin
        state_d   = state_q;
        sel_d_d   = sel_d_q;
        st_d      = st_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        last_d_d  = last_d_q;
        mem_addr  = '0;
        mem_din   = '0;
        mem_we    = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;

`ifdef RU_ARB_RR_EN
        // On contention take whichever port did not win last time.
        gnt_d = d_req && (!i_req || !last_d_q);
`else
        gnt_d = d_req;
`endif

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    sel_d_d  = gnt_d;
                    st_d     = gnt_d && d_we;
                    addr_d   = gnt_d ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
                    be_d     = d_be;
                    wdata_d  = d_wdata;
                    last_d_d = gnt_d;
                    mem_addr = addr_d;
                    if (gnt_d && d_we) begin
                        if (d_be == '1) begin
                            // Full word: write directly, no read needed.
                            mem_we  = 1'b1;
                            mem_din = d_wdata;
                            state_d = ACK;
                        end else if (d_be == '0) begin
                            state_d = ACK;
                        end else begin
                            state_d = READ;
                        end
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                mem_addr = addr_q;
                if (st_q) begin
                    // Merge: enabled lanes from store data, rest from old word.
                    mem_we = 1'b1;
                    for (int b = 0; b < BE_W; b++)
                        mem_din[b*8 +: 8] = be_q[b] ? wdata_q[b*8 +: 8]
                                                    : mem_dout[b*8 +: 8];
                end else if (sel_d_q) begin
                    d_rdata_d = mem_dout;
                end else begin
                    i_rdata_d = mem_dout;
                end
                state_d = ACK;
            end
            ACK: begin
                mem_addr = addr_q;
                i_ack    = !sel_d_q;
                d_ack    = sel_d_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abandon any in-flight access immediately while reset is held.
        if (rst) begin
            mem_we  = 1'b0;
            mem_din = '0;
            i_ack   = 1'b0;
            d_ack   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_d_q   <= 1'b0;
            st_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            last_d_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_d_q   <= sel_d_d;
            st_q      <= st_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            last_d_q  <= last_d_d;
        end
    end

endmodule

// File: tb/tb_ru_mem_arbiter.sv
// Self-checking bench for ru_mem_arbiter: a behavioural RAM plus a
// transaction-level reference memory; directed cases then random pairs.
module tb_ru_mem_arbiter;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we;
    logic [31:0]   i_addr, d_addr;
    logic [BW-1:0] d_be;
    logic [DW-1:0] d_wdata, i_rdata, d_rdata, mem_din, mem_dout;
    logic          i_ack, d_ack, mem_we;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    ru_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_dout(mem_dout)
    );

    // Registered-read RAM with a backdoor write port for preloading.
    logic [DW-1:0] mem     [2**AW];
    logic [DW-1:0] ref_mem [2**AW];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_idx = '0;
    logic [DW-1:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we)       mem[bd_idx]   <= bd_data;
        else if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    int          n_chk = 0;
    int          n_fail = 0;
    bit          last_was_d = 1'b0;
    logic [31:0] last_i = '0, last_d = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] idx(input logic [31:0] a);
        return a[AW+1:2];
    endfunction

    task automatic bd_write(input logic [AW-1:0] i, input logic [31:0] v);
        bd_idx = i; bd_data = v; bd_we = 1'b1;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref_mem[i] = v;
    endtask

    // Issue an I and/or D request in the same IDLE cycle and follow both
    // to completion. Starts and ends 1 time unit after a rising edge.
    task automatic run_pair(input bit doi, input logic [31:0] ia, input bit dod,
                            input bit we, input logic [3:0] be,
                            input logic [31:0] da, input logic [31:0] wd);
        int li, ld, ti, td, nwe, exp_we;
        bit d_first, ia_seen, da_seen;
        logic [31:0] ei, ed, w;
        li = 2;
        ld = (we && (be == 4'hF || be == 4'h0)) ? 1 : 2;
`ifdef RU_ARB_RR_EN
        d_first = dod && (!doi || !last_was_d);
`else
        d_first = dod;
`endif
        ti = -1; td = -1; ei = '0; ed = '0;
        if (doi && dod) begin
            if (d_first) begin td = ld; ti = ld + 1 + li; end
            else         begin ti = li; td = li + 1 + ld; end
        end else begin
            if (doi) ti = li;
            if (dod) td = ld;
        end
        // Reference effects, applied in grant order.
        if (doi && !d_first) ei = ref_mem[idx(ia)];
        if (dod) begin
            if (we) begin
                w = ref_mem[idx(da)];
                for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
                ref_mem[idx(da)] = w;
            end else ed = ref_mem[idx(da)];
        end
        if (doi && d_first) ei = ref_mem[idx(ia)];
        if (doi && dod) last_was_d = !d_first;
        else if (dod)   last_was_d = 1'b1;
        else if (doi)   last_was_d = 1'b0;
        exp_we = (dod && we && be != 4'h0) ? 1 : 0;

        i_req = doi; i_addr = ia;
        d_req = dod; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
        nwe = 0;
        for (int k = 0; k < 16 && (i_req || d_req); k++) begin
            #2;
            if (k == 0 && (doi ^ dod) && !(dod && we && be == 4'h0))
                chk("mem_addr_c0", 32'(mem_addr), 32'(doi ? idx(ia) : idx(da)));
            if (mem_we) nwe++;
            ia_seen = i_ack;
            da_seen = d_ack;
            if (ia_seen) begin
                chk("i_ack_cycle", k, ti);
                chk("i_rdata", i_rdata, ei);
            end
            if (da_seen) begin
                chk("d_ack_cycle", k, td);
                if (!we) chk("d_rdata", d_rdata, ed);
            end
            @(posedge clk); #1;
            if (ia_seen) i_req = 1'b0;
            if (da_seen) d_req = 1'b0;
        end
        chk("timeout", {31'b0, i_req | d_req}, 32'd0);
        i_req = 1'b0; d_req = 1'b0;
        chk("mem_we_count", nwe, exp_we);
        if (dod && we) chk("mem_word", mem[idx(da)], ref_mem[idx(da)]);
        if (doi) last_i = ei;
        if (dod && !we) last_d = ed;
        chk("i_rdata_hold", i_rdata, last_i);
        chk("d_rdata_hold", d_rdata, last_d);
    endtask

    initial begin
        rst = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; d_be = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 2**AW; i++) bd_write(AW'(i), $urandom);
        #2;
        chk("rst_i_ack", {31'b0, i_ack}, 0);
        chk("rst_d_ack", {31'b0, d_ack}, 0);
        chk("rst_mem_we", {31'b0, mem_we}, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fetch of a preloaded word.
        bd_write(4, 32'hDEADBEEF);
        run_pair(1, 32'h10, 0, 0, 4'h0, 0, 0);
        // Full store then load back.
        run_pair(0, 0, 1, 1, 4'hF, 32'h20, 32'h12345678);
        run_pair(0, 0, 1, 0, 4'h0, 32'h20, 0);
        // Partial store merges one lane.
        bd_write(8, 32'hAABBCCDD);
        run_pair(0, 0, 1, 1, 4'b0010, 32'h20, 32'h0000EE00);
        run_pair(0, 0, 1, 0, 4'h0, 32'h20, 0);
        chk("merge_word", mem[8], 32'hAABBEEDD);
        // Empty store leaves memory alone.
        run_pair(0, 0, 1, 1, 4'h0, 32'h24, 32'hFFFFFFFF);
        run_pair(0, 0, 1, 0, 4'h0, 32'h24, 0);
        // Contention, with aliased high address bits.
        for (int n = 0; n < 4; n++)
            run_pair(1, 32'hF000_0000 | 32'(n*4), 1, 0, 4'h0, 32'h0000_0030 | 32'(n*4), 0);

        // Reset during the read phase of a partial store.
        d_req = 1; d_we = 1; d_be = 4'b0010; d_addr = 32'h20; d_wdata = 32'h0000_5500;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("rst_read_mem_we", {31'b0, mem_we}, 0);
        chk("rst_read_d_ack", {31'b0, d_ack}, 0);
        chk("rst_read_i_ack", {31'b0, i_ack}, 0);
        @(posedge clk); #1;
        rst = 1'b0; d_req = 1'b0;
        last_was_d = 1'b0; last_i = '0; last_d = '0;
        chk("rst_read_mem8", mem[8], ref_mem[8]);
        run_pair(0, 0, 1, 0, 4'h0, 32'h20, 0);

        // Random mix.
        for (int n = 0; n < 300; n++) begin
            bit doi, dod, we;
            logic [3:0] be;
            int sel;
            doi = $urandom_range(0, 1);
            dod = $urandom_range(0, 1);
            if (!doi && !dod) dod = 1'b1;
            we  = $urandom_range(0, 1);
            sel = $urandom_range(0, 3);
            be  = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
            run_pair(doi, $urandom, dod, we, be, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
